spi_xfer_sequencer: RTL and testbench

//  Transaction sequencer in front of the byte-level SPI PHY. Accepts a command (length, flags, slave index),

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_byte_skid.sv | 36 +++
 rtl/spi_xfer_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_spi_xfer_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI transaction path
package spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFETCH,
    S_XFER,
    S_DRAIN,
    S_DONE
  } seq_state_t;

  localparam logic [7:0] SPI_FILL_BYTE = 8'hFF;

endpackage

// File: rtl/spi_byte_skid.sv
// rtl/spi_byte_skid.sv - one-entry valid/ready byte holding register
module spi_byte_skid (
  input  logic       clk,
  input  logic       nrst,
  input  logic       clr,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data
);

  logic       full;
  logic [7:0] data_q;

  // A pop frees the slot in the same cycle, so push and pop may coincide.
  assign in_ready  = !full || out_ready;
  assign out_valid = full;
  assign out_data  = data_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      full   <= 1'b0;
      data_q <= '0;
    end else if (clr) begin
      full <= 1'b0;
    end else if (in_valid && in_ready) begin
      data_q <= in_data;
      full   <= 1'b1;
    end else if (out_ready && full) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// rtl/spi_xfer_sequencer.sv - command-driven transaction sequencer in front of the byte-level SPI PHY
module spi_xfer_sequencer
  import spi_pkg::*;
#(
  parameter int         LEN_W     = 16,
  parameter int         N_CS      = 4,
  parameter logic [7:0] FILL_BYTE = SPI_FILL_BYTE,
  localparam int        CS_W      = (N_CS > 1) ? $clog2(N_CS) : 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_tx_en,
  input  logic             cmd_rx_en,
  input  logic [CS_W-1:0]  cmd_cs,
  input  logic             abort,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [7:0]       tx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [7:0]       rx_data,
  output logic             phy_ena,
  output logic [7:0]       phy_data_in,
  input  logic             phy_new_byte,
  input  logic [7:0]       phy_data_out,
  input  logic             phy_idle,
  input  logic             phy_cs_n,
  output logic [N_CS-1:0]  spi_cs_n,
  output logic             done,
  output logic             st_underrun,
  output logic             st_overrun,
  output logic             st_aborted
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  seq_state_t       state, next_state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] left;
  logic [LEN_W-1:0] fetched;
  logic             tx_en_q;
  logic             rx_en_q;
  logic [CS_W-1:0]  cs_q;

  logic             accept;
  logic             start;
  logic             pre_abort;
  logic             xfer_abort;
  logic             last_byte;
  logic             xfer_byte;
  logic             rx_capture;
  logic             fetch_ok;

  logic             hold_in_ready;
  logic             hold_valid;
  logic             hold_pop;
  logic [7:0]       hold_data;

  assign cmd_ready  = (state == S_IDLE);
  assign done       = (state == S_DONE);
  assign xfer_byte  = (state == S_XFER) && phy_new_byte;
  assign rx_capture = phy_new_byte && rx_en_q && ((state == S_XFER) || (state == S_DRAIN));

  // Total fetches are capped at len so nothing past this transaction leaves the upstream stream.
  assign fetch_ok = tx_en_q && !hold_valid && (fetched != len_q) &&
                    ((state == S_PREFETCH) || (state == S_XFER));
  assign tx_ready = fetch_ok && hold_in_ready;

  spi_byte_skid u_tx_hold (
    .clk       (clk),
    .nrst      (nrst),
    .clr       (accept),
    .in_valid  (tx_valid && fetch_ok),
    .in_ready  (hold_in_ready),
    .in_data   (tx_data),
    .out_valid (hold_valid),
    .out_ready (hold_pop),
    .out_data  (hold_data)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    start      = 1'b0;
    pre_abort  = 1'b0;
    xfer_abort = 1'b0;
    last_byte  = 1'b0;
    hold_pop   = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          accept     = 1'b1;
          next_state = (cmd_len == '0) ? S_DONE : S_PREFETCH;
        end
      end
      S_PREFETCH: begin
        if (abort) begin
          pre_abort  = 1'b1;
          next_state = S_DONE;
        end else if (!tx_en_q || hold_valid) begin
          start      = 1'b1;
          hold_pop   = tx_en_q;
          next_state = S_XFER;
        end
      end
      S_XFER: begin
        // A finishing byte wins over abort: the transfer is complete either way.
        if (xfer_byte && (left == LEN_ONE)) begin
          last_byte  = 1'b1;
          next_state = S_DRAIN;
        end else if (abort) begin
          xfer_abort = 1'b1;
          next_state = S_DRAIN;
        end
        if (xfer_byte && (left > LEN_ONE) && hold_valid) hold_pop = 1'b1;
      end
      S_DRAIN: begin
        if (phy_idle) next_state = S_DONE;
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      len_q       <= '0;
      left        <= '0;
      fetched     <= '0;
      tx_en_q     <= 1'b0;
      rx_en_q     <= 1'b0;
      cs_q        <= '0;
      phy_ena     <= 1'b0;
      phy_data_in <= FILL_BYTE;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      st_underrun <= 1'b0;
      st_overrun  <= 1'b0;
      st_aborted  <= 1'b0;
    end else begin
      if (accept) begin
        len_q       <= cmd_len;
        tx_en_q     <= cmd_tx_en;
        rx_en_q     <= cmd_rx_en;
        cs_q        <= cmd_cs;
        fetched     <= '0;
        st_underrun <= 1'b0;
        st_overrun  <= 1'b0;
        st_aborted  <= 1'b0;
      end
      if (tx_valid && tx_ready) fetched <= fetched + LEN_ONE;
      if (start) begin
        phy_ena     <= 1'b1;
        left        <= len_q;
        phy_data_in <= tx_en_q ? hold_data : FILL_BYTE;
      end
      if (pre_abort) st_aborted <= 1'b1;
      // Staging is refilled right after new_byte, ahead of the PHY's next load cycle.
      if (xfer_byte) begin
        if (left != '0) left <= left - LEN_ONE;
        if (left > LEN_ONE) begin
          if (hold_valid) begin
            phy_data_in <= hold_data;
          end else begin
            phy_data_in <= FILL_BYTE;
            if (tx_en_q) st_underrun <= 1'b1;
          end
        end
      end
      if (last_byte || xfer_abort) phy_ena <= 1'b0;
      if (xfer_abort) st_aborted <= 1'b1;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (rx_capture) begin
        if (rx_valid && !rx_ready) begin
          st_overrun <= 1'b1;
        end else begin
          rx_data  <= phy_data_out;
          rx_valid <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    spi_cs_n = '1;
    if (!phy_cs_n) spi_cs_n[cs_q] = 1'b0;
  end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// tb/tb_spi_xfer_sequencer.sv - scoreboard bench with a behavioural loopback PHY
module tb_spi_xfer_sequencer;

  localparam int BYTE_CYC = 64;

  typedef struct {
    bit und;
    bit ovr;
    bit abt;
    int nbytes;
  } st_exp_t;

  logic        clk = 1'b0;
  logic        nrst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_len;
  logic        cmd_tx_en;
  logic        cmd_rx_en;
  logic [1:0]  cmd_cs;
  logic        abort;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        phy_ena;
  logic [7:0]  phy_data_in;
  logic        phy_new_byte;
  logic [7:0]  phy_data_out;
  logic        phy_idle;
  logic        phy_cs_n;
  logic [3:0]  spi_cs_n;
  logic        done;
  logic        st_underrun;
  logic        st_overrun;
  logic        st_aborted;

  spi_xfer_sequencer dut (
    .clk          (clk),
    .nrst         (nrst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_len      (cmd_len),
    .cmd_tx_en    (cmd_tx_en),
    .cmd_rx_en    (cmd_rx_en),
    .cmd_cs       (cmd_cs),
    .abort        (abort),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .phy_ena      (phy_ena),
    .phy_data_in  (phy_data_in),
    .phy_new_byte (phy_new_byte),
    .phy_data_out (phy_data_out),
    .phy_idle     (phy_idle),
    .phy_cs_n     (phy_cs_n),
    .spi_cs_n     (spi_cs_n),
    .done         (done),
    .st_underrun  (st_underrun),
    .st_overrun   (st_overrun),
    .st_aborted   (st_aborted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [7:0] tx_src_q[$];
  logic [7:0] exp_mosi[$];
  logic [7:0] exp_rx[$];
  st_exp_t    exp_st[$];

  int tx_mode = 0;
  int rx_mode = 0;
  int cur_cs = 0;
  int done_cnt = 0;
  int done_base = 0;
  int nb_cnt = 0;
  int loads = 0;
  int txr_seen = 0;
  logic [3:0] cs_low_seen = 4'hF;
  bit cs_prev = 1'b1;

  bit         ph_busy = 1'b0;
  bit         ph_rel = 1'b0;
  int         ph_cnt = 0;
  logic [7:0] ph_byte = 8'h00;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  function automatic void fail(input string name);
    checks++;
    $display("FAIL %s: event missing or unexpected", name);
  endfunction

  // Loopback PHY, scoreboard monitors and stream drivers, all sampled away from the rising edge.
  always @(negedge clk) begin
    logic [3:0] cs_exp;
    if (!nrst) begin
      phy_new_byte = 1'b0;
      phy_idle     = 1'b1;
      phy_cs_n     = 1'b1;
      ph_busy      = 1'b0;
      ph_rel       = 1'b0;
      ph_cnt       = 0;
    end else begin
      phy_new_byte = 1'b0;
      if (ph_busy && ph_cnt > 0) begin
        ph_cnt--;
        if (ph_cnt == 0) begin
          phy_new_byte = 1'b1;
          phy_data_out = ph_byte;
          nb_cnt++;
        end
      end else if (ph_busy && !phy_ena) begin
        ph_busy  = 1'b0;
        phy_cs_n = 1'b1;
        ph_rel   = 1'b1;
      end else if (ph_rel) begin
        phy_idle = 1'b1;
        ph_rel   = 1'b0;
      end else if (phy_ena) begin
        ph_byte  = phy_data_in;
        ph_busy  = 1'b1;
        ph_cnt   = BYTE_CYC;
        phy_cs_n = 1'b0;
        phy_idle = 1'b0;
        loads++;
        if (exp_mosi.size() == 0) fail("mosi_unexpected");
        else check("mosi_byte", phy_data_in, exp_mosi.pop_front());
      end
    end
    tx_valid = (tx_src_q.size() > 0) && (tx_mode == 0 || $urandom_range(3) != 0);
    tx_data  = (tx_src_q.size() > 0) ? tx_src_q[0] : 8'h00;
    case (rx_mode)
      0:       rx_ready = 1'b1;
      1:       rx_ready = ($urandom_range(3) != 0);
      default: rx_ready = 1'b0;
    endcase
    #1;
    if (tx_valid && tx_ready) void'(tx_src_q.pop_front());
    if (tx_ready) txr_seen++;
    if (rx_valid && rx_ready) begin
      if (exp_rx.size() == 0) fail("rx_unexpected");
      else check("rx_byte", rx_data, exp_rx.pop_front());
    end
    if (done) begin
      st_exp_t e;
      done_cnt++;
      if (exp_st.size() == 0) begin
        fail("done_unexpected");
      end else begin
        e = exp_st.pop_front();
        check("st_underrun", st_underrun, e.und);
        check("st_overrun", st_overrun, e.ovr);
        check("st_aborted", st_aborted, e.abt);
        check("new_byte_count", nb_cnt, e.nbytes);
        check("cs_released_at_done", spi_cs_n, 4'hF);
      end
    end
    if (!phy_cs_n && cs_prev) begin
      cs_exp = 4'hF;
      cs_exp[cur_cs] = 1'b0;
      check("spi_cs_decode", spi_cs_n, cs_exp);
      cs_low_seen = spi_cs_n;
    end
    cs_prev = phy_cs_n;
  end

  task automatic check_reset_vals();
    check("rst_phy_ena", phy_ena, 0);
    check("rst_phy_data_in", phy_data_in, 8'hFF);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_done", done, 0);
    check("rst_status", {st_underrun, st_overrun, st_aborted}, 0);
    check("rst_cmd_ready", cmd_ready, 1);
  endtask

  task automatic expect_st(input bit und, input bit ovr, input bit abt, input int nbytes);
    st_exp_t e;
    e.und = und; e.ovr = ovr; e.abt = abt; e.nbytes = nbytes;
    exp_st.push_back(e);
  endtask

  task automatic issue_cmd(input int len, input bit txe, input bit rxe, input int cs);
    bit ok;
    @(negedge clk);
    done_base = done_cnt;
    nb_cnt    = 0;
    loads     = 0;
    cur_cs    = cs;
    cmd_len   = len[15:0];
    cmd_tx_en = txe;
    cmd_rx_en = rxe;
    cmd_cs    = cs[1:0];
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      #2;
      if (cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) fail("cmd_accept_timeout");
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    bit got;
    got = 1'b0;
    cyc = 0;
    for (int k = 0; k < 20000; k++) begin
      #2;
      if (done_cnt != done_base) begin got = 1'b1; break; end
      cyc++;
      @(negedge clk);
    end
    if (!got) fail("done_timeout");
  endtask

  // Reference: each slot sends the next upstream byte, or FILL when TX is off or starved.
  task automatic plan(input int len, input bit txe, input bit rxe, input int avail);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = $urandom_range(255);
      if (txe && i < avail) tx_src_q.push_back(b);
      else b = 8'hFF;
      exp_mosi.push_back(b);
      if (rxe) exp_rx.push_back(b);
    end
  endtask

  task automatic push_bytes(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    tx_src_q.push_back(b0); tx_src_q.push_back(b1); tx_src_q.push_back(b2);
  endtask

  initial begin
    int lat;
    int len;
    bit txe, rxe;
    nrst = 1'b0;
    cmd_valid = 1'b0; cmd_len = '0; cmd_tx_en = 1'b0; cmd_rx_en = 1'b0; cmd_cs = '0;
    abort = 1'b0;
    phy_data_out = 8'h00; phy_new_byte = 1'b0; phy_idle = 1'b1; phy_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    #1 check_reset_vals();
    check("rst_spi_cs_n", spi_cs_n, 4'hF);
    @(negedge clk);
    nrst = 1'b1;

    // Plain transfer with known bytes.
    push_bytes(8'hA5, 8'h3C, 8'h81);
    exp_mosi.push_back(8'hA5); exp_mosi.push_back(8'h3C); exp_mosi.push_back(8'h81);
    exp_rx.push_back(8'hA5); exp_rx.push_back(8'h3C); exp_rx.push_back(8'h81);
    expect_st(0, 0, 0, 3);
    issue_cmd(3, 1, 1, 0);
    wait_done(lat);
    repeat (4) @(negedge clk);
    check("single_done", done_cnt - done_base, 1);

    // TX disabled: fill bytes only, tx_ready stays low.
    txr_seen = 0;
    plan(2, 0, 1, 0);
    expect_st(0, 0, 0, 2);
    issue_cmd(2, 0, 1, 1);
    wait_done(lat);
    check("tx_ready_never", txr_seen, 0);

    // Upstream stalls after the first byte.
    plan(4, 1, 1, 1);
    expect_st(1, 0, 0, 4);
    issue_cmd(4, 1, 1, 3);
    wait_done(lat);

    // RX never drained: first byte held, rest dropped.
    rx_mode = 2;
    push_bytes(8'h11, 8'h22, 8'h33);
    exp_mosi.push_back(8'h11); exp_mosi.push_back(8'h22); exp_mosi.push_back(8'h33);
    exp_rx.push_back(8'h11);
    expect_st(0, 1, 0, 3);
    issue_cmd(3, 1, 1, 0);
    wait_done(lat);
    check("ovr_rx_valid", rx_valid, 1);
    check("ovr_rx_data", rx_data, 8'h11);
    check("ovr_cs_released", phy_cs_n, 1);
    rx_mode = 0;
    repeat (3) @(negedge clk);

    // Abort in the middle of byte 2 of 5.
    push_bytes(8'h01, 8'h02, 8'h03);
    tx_src_q.push_back(8'h04); tx_src_q.push_back(8'h05);
    exp_mosi.push_back(8'h01); exp_mosi.push_back(8'h02);
    exp_rx.push_back(8'h01); exp_rx.push_back(8'h02);
    expect_st(0, 0, 1, 2);
    loads = 0;
    fork
      begin
        issue_cmd(5, 1, 1, 1);
        wait_done(lat);
      end
      begin
        for (int k = 0; k < 2000 && loads < 2; k++) @(negedge clk);
        repeat (10) @(negedge clk);
        abort = 1'b1;
      end
    join
    abort = 1'b0;
    check("abort_unfetched_left", tx_src_q.size(), 2);
    tx_src_q.delete();

    // Zero length: done almost at once, PHY never started.
    expect_st(0, 0, 0, 0);
    issue_cmd(0, 1, 1, 0);
    wait_done(lat);
    check("len0_latency_ok", lat <= 1, 1);
    check("len0_no_load", loads, 0);

    // Slave select decode for index 2.
    cs_low_seen = 4'hF;
    plan(2, 1, 1, 2);
    expect_st(0, 0, 0, 2);
    issue_cmd(2, 1, 1, 2);
    wait_done(lat);
    check("cs2_pattern", cs_low_seen, 4'b1011);

    // Reset in the middle of a byte.
    plan(5, 1, 1, 5);
    issue_cmd(5, 1, 1, 3);
    for (int k = 0; k < 2000 && loads < 1; k++) @(negedge clk);
    repeat (20) @(negedge clk);
    nrst = 1'b0;
    #1 check_reset_vals();
    tx_src_q.delete(); exp_mosi.delete(); exp_rx.delete(); exp_st.delete();
    repeat (3) @(negedge clk);
    #1 check("rst_mid_spi_cs_n", spi_cs_n, 4'hF);
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // Randomised transactions against the reference.
    tx_mode = 1;
    rx_mode = 1;
    for (int t = 0; t < 12; t++) begin
      len = $urandom_range(1, 6);
      txe = $urandom_range(1);
      rxe = $urandom_range(1);
      plan(len, txe, rxe, len);
      expect_st(0, 0, 0, len);
      issue_cmd(len, txe, rxe, $urandom_range(3));
      wait_done(lat);
      repeat ($urandom_range(1, 5)) @(negedge clk);
    end
    rx_mode = 0;
    repeat (10) @(negedge clk);
    check("end_rx_drained", exp_rx.size(), 0);
    check("end_mosi_drained", exp_mosi.size(), 0);
    check("end_status_drained", exp_st.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
